// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Mode/direction encodings, full-scale and minimum-pulse cycle computations.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  // Full-scale level M = 2^W - 1 for a W-bit level.
  function automatic int unsigned f_full_scale(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Minimum pulse in clk cycles: ceil(min_pulse_ns * clk_frq / 1e9).
  function automatic int unsigned f_min_pulse_cycles(input int unsigned min_pulse_ns,
                                                     input int unsigned clk_frq);
    longint unsigned prod;
    prod = longint'(min_pulse_ns) * longint'(clk_frq);
    return int'((prod + 64'd999999999) / 64'd1000000000);
  endfunction

endpackage

// File: rtl/pwm_hold.sv
// Per-channel output stage: enforces a minimum stable time of K clk on each level.
// With K <= 1 it degenerates to a plain register.
module pwm_hold
  import pwm_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic raw,
  output logic out
);

  if (K <= 1) begin : g_reg
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        out <= 1'b0;
      end else if (clr) begin
        out <= 1'b0;
      end else begin
        out <= raw;
      end
    end
  end else begin : g_hold
    localparam int unsigned HW = $clog2(K + 1);
    localparam logic [HW-1:0] RELOAD = HW'(K - 1);

    logic [HW-1:0] hold;

    // Toggles requested while hold is running are deferred; out then follows raw.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        out  <= 1'b0;
        hold <= '0;
      end else if (clr) begin
        out  <= 1'b0;
        hold <= '0;
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
      end else if (raw != out) begin
        out  <= raw;
        hold <= RELOAD;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, edge/centre alignment,
// double-buffered levels swapped at the period boundary, per-channel min-pulse stage.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ        = 100000000,
  parameter int unsigned C_MIN_PULSE      = 0,
  parameter int unsigned C_LEVEL_WIDTH    = 8,
  parameter int unsigned C_CHANNELS       = 4,
  parameter int unsigned C_PRESCALE_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  en,
  input  logic                                  center,
  input  logic [C_PRESCALE_WIDTH-1:0]           prescale,
  input  logic [C_CHANNELS*C_LEVEL_WIDTH-1:0]   level,
  input  logic                                  level_valid,
  output logic                                  level_ready,
  output logic                                  period_start,
  output logic [C_CHANNELS-1:0]                 out
);

  localparam int unsigned W = C_LEVEL_WIDTH;
  localparam int unsigned N = C_CHANNELS;
  localparam int unsigned P = C_PRESCALE_WIDTH;
  localparam logic [W-1:0] C_FULL = W'(f_full_scale(W));
  localparam logic [W-1:0] C_TOP  = W'(f_full_scale(W) - 1);
  localparam int unsigned  C_K    = f_min_pulse_cycles(C_MIN_PULSE, C_CLK_FRQ);

  logic [P-1:0]   pc;
  logic [P-1:0]   prescale_a;
  logic [W-1:0]   cnt;
  pwm_dir_t       dir;
  pwm_mode_t      mode_a;
  logic [N*W-1:0] shadow;
  logic [N*W-1:0] active;
  logic           pending;
  logic           running;
  logic [N-1:0]   raw;
  logic [N-1:0]   raw_nxt;
  logic           tick;
  logic           wrap;
  logic           boundary;
  logic           write;

  always_comb begin
    tick = (pc == prescale_a);
    wrap = 1'b0;
    if (tick) begin
      if (mode_a == MODE_EDGE) begin
        wrap = (cnt == C_TOP);
      end else begin
        wrap = (dir == DIR_DOWN) && (cnt == '0);
      end
    end
    // The first enabled clk after idle or reset also counts as a boundary.
    boundary = en && (!running || wrap);
    write    = level_valid && !pending;
  end

  always_comb begin
    raw_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mode_a == MODE_EDGE) begin
        raw_nxt[i] = (cnt < active[i*W +: W]);
      end else begin
        raw_nxt[i] = (cnt >= (C_FULL - active[i*W +: W]));
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      running      <= 1'b0;
      pc           <= '0;
      prescale_a   <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_a       <= MODE_EDGE;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      raw          <= '0;
    end else if (!en) begin
      running      <= 1'b0;
      pc           <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      active       <= shadow;
      pending      <= 1'b0;
      period_start <= 1'b0;
      raw          <= '0;
      if (level_valid) begin
        shadow <= level;
      end
    end else begin
      running      <= 1'b1;
      period_start <= boundary;
      raw          <= raw_nxt;

      if (!running) begin
        pc  <= '0;
        cnt <= '0;
        dir <= DIR_UP;
      end else if (tick) begin
        pc <= '0;
        if (mode_a == MODE_EDGE) begin
          cnt <= wrap ? '0 : cnt + W'(1);
          dir <= DIR_UP;
        end else if (dir == DIR_UP) begin
          // Centre mode dwells one tick at each turning point while dir flips.
          if (cnt == C_TOP) begin
            dir <= DIR_DOWN;
          end else begin
            cnt <= cnt + W'(1);
          end
        end else begin
          if (cnt == '0) begin
            dir <= DIR_UP;
          end else begin
            cnt <= cnt - W'(1);
          end
        end
      end else begin
        pc <= pc + P'(1);
      end

      if (boundary) begin
        active     <= shadow;
        mode_a     <= pwm_mode_t'(center);
        prescale_a <= prescale;
        pending    <= 1'b0;
      end
      // A write landing on the boundary is kept for the following period.
      if (write) begin
        shadow  <= level;
        pending <= 1'b1;
      end
    end
  end

  assign level_ready = ~pending;

  for (genvar g = 0; g < N; g++) begin : g_ch
    pwm_hold #(
      .K(C_K)
    ) u_hold (
      .clk  (clk),
      .rstb (rstb),
      .clr  (~en),
      .raw  (raw[g]),
      .out  (out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: per-period high counts, first/last high offsets
// and period length are compared against hand-computed expectations.
module tb_pwm_multi;

  typedef logic [3:0][15:0] v4_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] len;
    v4_t         hi;
    v4_t         first;
    v4_t         last;
  } exp_t;

  localparam logic [15:0] NONE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en;
  logic        center;
  logic [7:0]  prescale;
  logic [31:0] level;
  logic        level_valid;
  logic        rdy_a, ps_a, rdy_m, ps_m;
  logic [3:0]  out_a, out_m;
  logic        use_mp;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_multi #(
    .C_CLK_FRQ(100000000), .C_MIN_PULSE(0), .C_LEVEL_WIDTH(8),
    .C_CHANNELS(4), .C_PRESCALE_WIDTH(8)
  ) u_dut (
    .clk(clk), .rstb(rstb), .en(en), .center(center), .prescale(prescale),
    .level(level), .level_valid(level_valid), .level_ready(rdy_a),
    .period_start(ps_a), .out(out_a)
  );

  pwm_multi #(
    .C_CLK_FRQ(100000000), .C_MIN_PULSE(100), .C_LEVEL_WIDTH(8),
    .C_CHANNELS(4), .C_PRESCALE_WIDTH(8)
  ) u_dut_mp (
    .clk(clk), .rstb(rstb), .en(en), .center(center), .prescale(prescale),
    .level(level), .level_valid(level_valid), .level_ready(rdy_m),
    .period_start(ps_m), .out(out_m)
  );

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int id, input int len, input v4_t hi, input v4_t fi, input v4_t la);
    exp_t e;
    e.id    = 8'(id);
    e.len   = 16'(len);
    e.hi    = hi;
    e.first = fi;
    e.last  = la;
    sb.push_back(e);
  endtask

  // Monitor: windows are aligned to period_start delayed by the 2-clk output latency.
  logic [1:0] psd;
  logic       d2;
  logic       measuring;
  logic [3:0] o;
  int         mlen;
  v4_t        mhi, mfirst, mlast;

  task automatic close_window();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_period", 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("p%0d_len", e.id), mlen, int'(e.len));
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("p%0d_ch%0d_high", e.id, c), int'(mhi[c]), int'(e.hi[c]));
        chk($sformatf("p%0d_ch%0d_first", e.id, c), int'(mfirst[c]), int'(e.first[c]));
        chk($sformatf("p%0d_ch%0d_last", e.id, c), int'(mlast[c]), int'(e.last[c]));
      end
    end
  endtask

  initial begin
    psd = '0;
    measuring = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        psd = '0;
        measuring = 1'b0;
        sb.delete();
      end else begin
        d2  = psd[1];
        psd = {psd[0], ps_a};
        o   = use_mp ? out_m : out_a;
        if (d2) begin
          if (measuring) close_window();
          measuring = 1'b1;
          mlen = 0;
          for (int c = 0; c < 4; c++) begin
            mhi[c] = '0; mfirst[c] = NONE; mlast[c] = NONE;
          end
        end
        if (measuring) begin
          for (int c = 0; c < 4; c++) begin
            if (o[c]) begin
              if (mfirst[c] == NONE) mfirst[c] = 16'(mlen);
              mlast[c] = 16'(mlen);
              mhi[c]   = mhi[c] + 16'd1;
            end
          end
          mlen++;
        end
      end
    end
  end

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps_a !== 1'b1 && n < 3000);
    if (ps_a !== 1'b1) chk("ps_timeout", 0, 1);
  endtask

  task automatic write_level(input logic [31:0] v);
    level = v;
    level_valid = 1'b1;
    @(negedge clk);
    level_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; en = 1'b0; center = 1'b0; prescale = 8'd0;
    level = '0; level_valid = 1'b0; use_mp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out_a), 0);
    chk("rst_ps", int'(ps_a), 0);
    chk("rst_ready", int'(rdy_a), 1);
    chk("rst_out_mp", int'(out_m), 0);
    chk("rst_ready_mp", int'(rdy_m), 1);
    rstb = 1'b1;
    @(negedge clk);

    // Idle: write captured without blocking the handshake.
    write_level({8'd255, 8'd128, 8'd1, 8'd0});
    chk("idle_ready", int'(rdy_a), 1);
    repeat (3) @(negedge clk);
    chk("idle_out", int'(out_a), 0);
    chk("idle_ps", int'(ps_a), 0);
    en = 1'b1;

    // Edge mode, L = {0,1,128,255}
    wait_ps();
    push(1, 255, {16'd255, 16'd128, 16'd1, 16'd0}, {16'd0, 16'd0, 16'd0, NONE}, {16'd254, 16'd127, 16'd0, NONE});
    wait_ps();
    push(2, 255, {16'd255, 16'd128, 16'd1, 16'd0}, {16'd0, 16'd0, 16'd0, NONE}, {16'd254, 16'd127, 16'd0, NONE});

    // Mid-period write at cnt=50 keeps the old levels for this period
    wait_ps();
    push(3, 255, {16'd255, 16'd128, 16'd1, 16'd0}, {16'd0, 16'd0, 16'd0, NONE}, {16'd254, 16'd127, 16'd0, NONE});
    repeat (50) @(negedge clk);
    write_level({8'd255, 8'd0, 8'd10, 8'd200});
    chk("wr_ready_low", int'(rdy_a), 0);
    level = {8'd7, 8'd7, 8'd7, 8'd7};
    level_valid = 1'b1;
    repeat (5) @(negedge clk);
    level_valid = 1'b0;
    chk("wr_ready_still_low", int'(rdy_a), 0);

    wait_ps();
    chk("boundary_ready", int'(rdy_a), 1);
    push(4, 255, {16'd255, 16'd0, 16'd10, 16'd200}, {16'd0, NONE, 16'd0, 16'd0}, {16'd254, NONE, 16'd9, 16'd199});
    wait_ps();
    push(5, 255, {16'd255, 16'd0, 16'd10, 16'd200}, {16'd0, NONE, 16'd0, 16'd0}, {16'd254, NONE, 16'd9, 16'd199});
    write_level({8'd128, 8'd128, 8'd128, 8'd128});
    prescale = 8'd3;

    // prescale=3, L=128
    wait_ps();
    push(6, 1020, {16'd512, 16'd512, 16'd512, 16'd512}, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd511, 16'd511, 16'd511, 16'd511});
    write_level({8'd128, 8'd255, 8'd0, 8'd64});
    center = 1'b1;
    prescale = 8'd0;

    // Centre mode, L = {64,0,255,128}
    wait_ps();
    push(7, 510, {16'd256, 16'd510, 16'd0, 16'd128}, {16'd127, 16'd0, NONE, 16'd191}, {16'd382, 16'd509, NONE, 16'd318});
    write_level({8'd255, 8'd20, 8'd0, 8'd3});
    center = 1'b0;

    // Minimum-pulse instance (K=10), L = {3,0,20,255}
    wait_ps();
    use_mp = 1'b1;
    push(8, 255, {16'd255, 16'd20, 16'd0, 16'd10}, {16'd0, 16'd0, NONE, 16'd0}, {16'd254, 16'd19, NONE, 16'd9});

    // Asynchronous reset mid-period
    wait_ps();
    repeat (100) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("async_rst_out", int'(out_a), 0);
    chk("async_rst_out_mp", int'(out_m), 0);
    chk("async_rst_ps", int'(ps_a), 0);
    chk("async_rst_ready", int'(rdy_a), 1);
    repeat (2) @(negedge clk);
    rstb = 1'b1;

    wait_ps();
    push(10, 255, {16'd0, 16'd0, 16'd0, 16'd0}, {NONE, NONE, NONE, NONE}, {NONE, NONE, NONE, NONE});
    wait_ps();
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
